servo_pwm_driver: RTL and testbench

Downstream stage of the IPD servo controller (Solo_IPD_Truncamiento). Consumes the controller's signed fixed-point output `salida` and converts it to a sign/magnitude PWM drive (pwm_out + dir_out) for the motor H-bridge. Applies saturation, period-synchronous double-buffered updates, and a dead period on direction reversal. Generates the `en` sample strobe that paces the controller.

---
 rtl/servo_pwm_driver.sv | 131 +++++++++++++
 tb/tb_servo_pwm_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// Sign/magnitude PWM driver for the IPD servo controller output: saturates the
// request, reloads duty once per period, inserts a dead period on reversal.
module servo_pwm_driver #(
  parameter int cant_bits  = 16,
  parameter int PWM_BITS   = 10,
  parameter int PERIOD     = 1000,
  parameter int SHIFT      = 5,
  parameter int SAMPLE_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [cant_bits-1:0] u_in,
  input  logic                        u_valid,
  output logic                        ctrl_en,
  output logic                        pwm_out,
  output logic                        dir_out,
  output logic                        per_start,
  output logic [PWM_BITS-1:0]         duty_act,
  output logic                        sat_flag
);

  localparam int IDX_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t              state, state_nxt;
  logic [PWM_BITS-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]    per_idx, idx_nxt;
  logic [PWM_BITS-1:0] pend_duty, cap_duty, ld_duty, duty_nxt;
  logic                pend_dir, cap_sat, ld_dir, dir_nxt, wrap, capture;

  function automatic logic [cant_bits-2:0] abs_sat(input logic signed [cant_bits-1:0] u);
    logic signed [cant_bits-1:0] neg;
    neg = -u;
    if (!u[cant_bits-1]) return u[cant_bits-2:0];
    if (neg[cant_bits-1]) return '1;  // most-negative input has no positive twin
    return neg[cant_bits-2:0];
  endfunction

  // Returns {saturated, duty}
  function automatic logic [PWM_BITS:0] clamp_duty(input logic [cant_bits-2:0] mag);
    logic [cant_bits-2:0] req;
    req = mag >> SHIFT;
    if (int'(req) > PERIOD) return {1'b1, PWM_BITS'(PERIOD)};
    return {1'b0, PWM_BITS'(req)};
  endfunction

  always_comb begin
    {cap_sat, cap_duty} = clamp_duty(abs_sat(u_in));
    capture   = en & u_valid;
    // A capture on the wrap cycle must reach the boundary load directly
    ld_duty   = capture ? cap_duty : pend_duty;
    ld_dir    = capture ? u_in[cant_bits-1] : pend_dir;
    wrap      = (cnt == PWM_BITS'(PERIOD - 1));
    cnt_nxt   = wrap ? '0 : cnt + 1'b1;
    idx_nxt   = per_idx;
    if (wrap) idx_nxt = (per_idx == IDX_W'(SAMPLE_DIV - 1)) ? '0 : per_idx + 1'b1;
    state_nxt = state;
    duty_nxt  = duty_act;
    dir_nxt   = dir_out;
    if (wrap) begin
      case (state)
        RUN: begin
          dir_nxt = ld_dir;
          if (ld_dir == dir_out || duty_act == '0) begin
            duty_nxt = ld_duty;
          end else begin
            state_nxt = DEAD;
            duty_nxt  = '0;
          end
        end
        DEAD: begin
          state_nxt = RUN;
          duty_nxt  = ld_duty;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      per_idx   <= '0;
      pend_duty <= '0;
      pend_dir  <= 1'b0;
      duty_act  <= '0;
      dir_out   <= 1'b0;
      pwm_out   <= 1'b0;
      ctrl_en   <= 1'b0;
      per_start <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      cnt       <= '0;
      per_idx   <= '0;
      pend_duty <= '0;
      pend_dir  <= 1'b0;
      duty_act  <= '0;
      pwm_out   <= 1'b0;
      ctrl_en   <= 1'b0;
      per_start <= 1'b0;
    end else begin
      if (u_valid) begin
        pend_duty <= cap_duty;
        pend_dir  <= u_in[cant_bits-1];
        sat_flag  <= cap_sat;
      end
      if (state == IDLE) begin
        state     <= RUN;
        cnt       <= '0;
        per_idx   <= '0;
        per_start <= 1'b1;
        ctrl_en   <= 1'b1;
        pwm_out   <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        per_idx   <= idx_nxt;
        duty_act  <= duty_nxt;
        dir_out   <= dir_nxt;
        per_start <= (cnt_nxt == '0);
        ctrl_en   <= (cnt_nxt == '0) && (idx_nxt == '0);
        pwm_out   <= (state_nxt == RUN) && (cnt_nxt < duty_nxt);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver: directed scenarios plus random traffic, all
// checked every cycle against a time-based period model.
module tb_servo_pwm_driver;

  localparam int CB = 16, PB = 10, PERIOD = 1000, SHIFT = 5, SDIV = 4;

  logic                 clk = 1'b0;
  logic                 rst, en, u_valid;
  logic signed [CB-1:0] u_in;
  logic                 ctrl_en, pwm_out, dir_out, per_start, sat_flag;
  logic [PB-1:0]        duty_act;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  bit m_run = 0, m_dead = 0, m_dir = 0, m_pdir = 0, m_sat = 0;
  int m_t = 0, m_duty = 0, m_pduty = 0;

  servo_pwm_driver #(.cant_bits(CB), .PWM_BITS(PB), .PERIOD(PERIOD),
                     .SHIFT(SHIFT), .SAMPLE_DIV(SDIV)) dut (
    .clk(clk), .rst(rst), .en(en), .u_in(u_in), .u_valid(u_valid),
    .ctrl_en(ctrl_en), .pwm_out(pwm_out), .dir_out(dir_out),
    .per_start(per_start), .duty_act(duty_act), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
  endtask

  task automatic step();
    bit r, e, v;
    int s, mag, req;
    logic [31:0] obs, exp;
    bit e_pwm, e_ps, e_ce;
    r = rst; e = en; v = u_valid; s = int'(u_in);
    @(posedge clk); #1;
    if (r) begin
      m_run = 0; m_dead = 0; m_dir = 0; m_pdir = 0; m_sat = 0; m_duty = 0; m_pduty = 0;
    end else if (!e) begin
      m_run = 0; m_dead = 0; m_duty = 0; m_pduty = 0; m_pdir = 0;
    end else begin
      if (v) begin
        mag = (s < 0) ? ((s == -32768) ? 32767 : -s) : s;
        req = mag / (1 << SHIFT);
        m_sat   = (req > PERIOD);
        m_pduty = m_sat ? PERIOD : req;
        m_pdir  = (s < 0);
      end
      if (!m_run) begin
        m_run = 1; m_t = 0; m_dead = 0;
      end else begin
        m_t++;
        if (m_t % PERIOD == 0) begin
          if (m_dead) begin
            m_dead = 0; m_duty = m_pduty;
          end else if (m_pdir == m_dir || m_duty == 0) begin
            m_dir = m_pdir; m_duty = m_pduty;
          end else begin
            m_dead = 1; m_dir = m_pdir; m_duty = 0;
          end
        end
      end
    end
    e_ps  = m_run && (m_t % PERIOD == 0);
    e_ce  = m_run && (m_t % (PERIOD * SDIV) == 0);
    e_pwm = m_run && !m_dead && ((m_t % PERIOD) < m_duty);
    obs = {17'd0, pwm_out, dir_out, per_start, ctrl_en, sat_flag, duty_act};
    exp = {17'd0, e_pwm, m_dir, e_ps, e_ce, m_sat, PB'(m_duty)};
    chk("cycle{pwm,dir,ps,ce,sat,duty}", obs, exp);
  endtask

  task automatic pulse(input logic [15:0] val);
    u_in = val; u_valid = 1'b1;
    step();
    u_valid = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    int k = 0;
    do begin
      step(); k++;
    end while ((!m_run || (m_t % PERIOD) != ph) && k < 3 * PERIOD);
    if (k >= 3 * PERIOD) chk("phase_timeout", 0, 1);
  endtask

  // Counts pwm high cycles over one period, starting with the current cycle
  task automatic count_period(output int hi);
    hi = int'(pwm_out);
    repeat (PERIOD - 1) begin
      step();
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    int hi;
    int ce_pos[$];
    rst = 1'b1; en = 1'b1; u_valid = 1'b0; u_in = '0;

    // 1: reset with traffic present
    for (int i = 0; i < 3; i++) begin
      u_valid = i[0]; u_in = 16'h4B00;
      step();
      chk("rst_outputs", {pwm_out, dir_out, per_start, ctrl_en, sat_flag, duty_act}, '0);
    end
    rst = 1'b0; u_valid = 1'b0;
    step();
    chk("first_per_start", per_start, 1);
    chk("first_ctrl_en", ctrl_en, 1);

    // 2: +150.0 -> 600 counts
    run_to_phase(20);
    pulse(16'h4B00);
    run_to_phase(0);
    chk("p2_duty", duty_act, 600);
    chk("p2_dir", dir_out, 0);
    chk("p2_sat", sat_flag, 0);
    count_period(hi);
    chk("p2_high_cycles", hi, 600);

    // 3: most-negative -> saturation, dead period, then full duty
    run_to_phase(10);
    pulse(16'h8000);
    chk("p3_sat", sat_flag, 1);
    run_to_phase(0);
    chk("p3_dead_dir", dir_out, 1);
    chk("p3_dead_duty", duty_act, 0);
    count_period(hi);
    chk("p3_dead_high", hi, 0);
    step();
    chk("p3_full_duty", duty_act, 1000);
    count_period(hi);
    chk("p3_full_high", hi, 1000);

    // 4: last capture wins; capture on the wrap cycle is applied immediately
    run_to_phase(5);
    pulse(16'hF000);
    run_to_phase(100);
    pulse(16'hE000);
    run_to_phase(0);
    chk("p4_last_wins", duty_act, 256);
    run_to_phase(999);
    pulse(16'hD000);
    chk("p4_bypass", duty_act, 384);
    // reversal from zero duty needs no dead period
    run_to_phase(50);
    pulse(16'hFFFF);
    run_to_phase(0);
    chk("p4_zero_duty", duty_act, 0);
    run_to_phase(50);
    pulse(16'h0C80);
    run_to_phase(0);
    chk("p4_rev_duty", duty_act, 100);
    chk("p4_rev_dir", dir_out, 0);
    chk("p4_rev_pwm", pwm_out, 1);

    // 5: sample strobe spacing
    en = 1'b0;
    step(); step();
    en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (ctrl_en) ce_pos.push_back(i);
    end
    chk("p5_ce_count", ce_pos.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < ce_pos.size()) chk("p5_ce_pos", ce_pos[i], i * PERIOD * SDIV);
    end

    // 6: drop enable mid-pulse, re-enable
    pulse(16'h4B00);
    run_to_phase(0);
    run_to_phase(300);
    chk("p6_pwm_before", pwm_out, 1);
    en = 1'b0;
    step();
    chk("p6_pwm_off", pwm_out, 0);
    chk("p6_duty_off", duty_act, 0);
    en = 1'b1;
    step();
    chk("p6_re_ps", per_start, 1);
    chk("p6_re_ce", ctrl_en, 1);
    chk("p6_re_duty", duty_act, 0);
    run_to_phase(0);
    chk("p6_duty_still0", duty_act, 0);

    // Random traffic
    for (int i = 0; i < 30000; i++) begin
      rst     = ($urandom_range(0, 9999) == 0);
      if (!en) en = ($urandom_range(0, 3) == 0);
      else     en = ($urandom_range(0, 2999) != 0);
      u_valid = ($urandom_range(0, 199) == 0);
      u_in    = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12000) - 6000);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
